lite16_prog_loader: RTL and testbench

- Writer side of the LITE-16 instruction ROM; the program counter/fetch path is the reader.
- Accepts a framed byte stream over a valid/ready handshake.
- Assembles little-endian 16-bit words and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset until a frame with a valid checksum has been loaded.

---
 rtl/lite16_pkg.sv | 28 ++
 rtl/lite16_byte_pack.sv | 49 ++++
 rtl/lite16_prog_loader.sv | 203 ++++++++++++++++++++
 tb/tb_lite16_prog_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lite16_pkg.sv
// ---------------------------------------------------------------------------
// lite16_pkg
// Shared definitions for the LITE-16 program loader:
//   - loader_state_t : loader FSM state encoding
//   - LITE16_WORD_W  : instruction word width
//   - capacity()     : instruction-memory depth in words for a FULL_MEM setting
// ---------------------------------------------------------------------------
package lite16_pkg;

  localparam int LITE16_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

  // Depth in words. 17 bits so that the full 64K depth is representable.
  function automatic logic [16:0] capacity(input bit full_mem);
    return full_mem ? 17'd65536 : 17'd256;
  endfunction

endpackage

// File: rtl/lite16_byte_pack.sv
// ---------------------------------------------------------------------------
// lite16_byte_pack
// Pairs little-endian LO/HI bytes into one instruction word and keeps the
// running XOR checksum of the frame.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : restart the checksum (new frame)
//   xor_en       : fold data into the checksum this cycle
//   lo_en, hi_en : data is the LO / HI byte of a word this cycle
//   data         : incoming byte
//   word_valid   : one-cycle pulse, cycle after the HI byte
//   word         : assembled word {HI, LO}, held until the next HI byte
//   chk          : running XOR of every byte folded in since clear
// ---------------------------------------------------------------------------
module lite16_byte_pack
  import lite16_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     xor_en,
  input  logic                     lo_en,
  input  logic                     hi_en,
  input  logic [7:0]               data,
  output logic                     word_valid,
  output logic [LITE16_WORD_W-1:0] word,
  output logic [7:0]               chk
);

  logic [7:0] lo_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      chk        <= '0;
    end else begin
      word_valid <= hi_en;
      if (lo_en) lo_q <= data;
      if (hi_en) word <= {data, lo_q};
      if (clear)       chk <= '0;
      else if (xor_en) chk <= chk ^ data;
    end
  end

endmodule

// File: rtl/lite16_prog_loader.sv
// ---------------------------------------------------------------------------
// lite16_prog_loader
// Writer side of the LITE-16 instruction ROM. Receives a framed byte stream
//   LEN_LO LEN_HI {LO HI} x N CHK
// over valid/ready, writes N little-endian words from address 0 and keeps
// the CPU in reset until a frame with a correct XOR checksum has loaded.
//
// Parameters:
//   FULL_MEM       : 0 -> 256 words, 1 -> 65536 words
//   TIMEOUT_CYCLES : idle-byte watchdog limit (LITE16_LOADER_TIMEOUT_EN only)
// Optional feature macro: LITE16_LOADER_TIMEOUT_EN enables the watchdog that
//   aborts a frame after TIMEOUT_CYCLES cycles without a byte transfer.
//
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   start          : one-cycle pulse, begins a load (ignored while busy)
//   in_data/valid  : byte stream in;  in_ready: byte accepted this cycle
//   mem_we/addr/wdata : registered instruction-memory write port
//   cpu_hold       : 1 keeps the CPU in reset
//   busy           : frame in progress
//   done / error   : sticky result of the last frame
//   words_loaded   : words written in the current or last frame
// ---------------------------------------------------------------------------
module lite16_prog_loader
  import lite16_pkg::*;
#(
  parameter bit          FULL_MEM       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [15:0]              mem_addr,
  output logic [LITE16_WORD_W-1:0] mem_wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              words_loaded
);

  localparam logic [16:0] CAPACITY = capacity(FULL_MEM);

  loader_state_t state, state_next;

  logic        xfer;
  logic        start_go;
  logic        timeout_hit;
  logic        last_word;
  logic        lo_en, hi_en, xor_en;
  logic [15:0] len_q;
  logic [15:0] len_rx;
  logic [7:0]  chk;

  assign xfer     = in_valid & in_ready;
  assign start_go = start & ~busy;

  // Full length as seen during the LEN_HI transfer (HI byte is on the bus).
  assign len_rx    = {in_data, len_q[7:0]};
  // words_loaded has not yet counted the word completing this cycle.
  assign last_word = (words_loaded + 16'd1) == len_q;

  assign lo_en  = xfer && (state == ST_DATA_LO);
  assign hi_en  = xfer && (state == ST_DATA_HI);
  // The check byte itself is compared, not folded in.
  assign xor_en = xfer && (state != ST_CHECK);

  // -------------------------------------------------------------------------
  // Idle-byte watchdog
  // -------------------------------------------------------------------------
`ifdef LITE16_LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           idle_cnt <= '0;
    else if (start_go || xfer || !busy) idle_cnt <= '0;
    else                                idle_cnt <= idle_cnt + 32'd1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a transfer.
  assign timeout_hit = busy && !xfer && (idle_cnt >= (TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_hit = 1'b0;

  // Watchdog compiled out; the parameter stays for a uniform interface.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_rx == 16'd0)                 state_next = ST_CHECK;
          else if ({1'b0, len_rx} > CAPACITY)  state_next = ST_ERR;
          else                                 state_next = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) state_next = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        if (xfer) state_next = last_word ? ST_CHECK : ST_DATA_LO;
      end
      ST_CHECK: begin
        if (xfer) state_next = (in_data == chk) ? ST_DONE : ST_ERR;
      end
      default: state_next = ST_IDLE;
    endcase
    if (timeout_hit) state_next = ST_ERR;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (decoded from the registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Length capture, word counter and write address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
    end else if (xfer) begin
      if (state == ST_LEN_LO) len_q[7:0]  <= in_data;
      if (state == ST_LEN_HI) len_q[15:8] <= in_data;
    end
  end

  // mem_addr and words_loaded move on the same edge that raises mem_we, so
  // the address shown with the strobe is the 0-based index of that word.
  // The length check bounds the index below capacity, so it cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_loaded <= '0;
      mem_addr     <= '0;
    end else if (start_go) begin
      words_loaded <= '0;
      mem_addr     <= '0;
    end else if (hi_en) begin
      mem_addr     <= words_loaded;
      words_loaded <= words_loaded + 16'd1;
    end
  end

  lite16_byte_pack u_byte_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_go),
    .xor_en     (xor_en),
    .lo_en      (lo_en),
    .hi_en      (hi_en),
    .data       (in_data),
    .word_valid (mem_we),
    .word       (mem_wdata),
    .chk        (chk)
  );

endmodule

// File: tb/tb_lite16_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_lite16_prog_loader
// Self-checking bench for lite16_prog_loader (FULL_MEM=0, 256 words).
// Frames are fed with random valid gaps and random start pulses mid-frame;
// a frame-level reference model predicts the writes, the final flags,
// words_loaded and how many bytes the loader should consume.
// With LITE16_LOADER_TIMEOUT_EN the watchdog is exercised at 16 cycles.
// ---------------------------------------------------------------------------
module tb_lite16_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  localparam int CAP = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_chk = 0;
  int n_err = 0;

  // Captured writes {addr, data} and model expectations.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_words;
  int          exp_consumed;
  byte_q_t     fb;

  always #5 clk = ~clk;

  lite16_prog_loader #(
    .FULL_MEM       (1'b0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: parse the byte list by the frame rules.
  function automatic void model(input byte_q_t b);
    int         n;
    logic [7:0] x;
    exp_q.delete();
    n = int'({b[1], b[0]});
    if (n > CAP) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_words = 0; exp_consumed = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * n; i++) x ^= b[i];
    for (int i = 0; i < n; i++) exp_q.push_back({16'(i), b[3 + 2 * i], b[2 + 2 * i]});
    exp_words    = n;
    exp_consumed = 3 + 2 * n;
    exp_done     = (b[2 + 2 * n] == x);
    exp_err      = !exp_done;
  endfunction

  task automatic build_frame(input int n, input bit good);
    logic [7:0] x;
    fb.delete();
    fb.push_back(8'(n));
    fb.push_back(8'(n >> 8));
    for (int i = 0; i < 2 * n; i++) fb.push_back(8'($urandom));
    x = 8'h00;
    foreach (fb[i]) x ^= fb[i];
    fb.push_back(good ? x : x ^ 8'($urandom_range(255, 1)));
  endtask

  // One start pulse, with a junk byte offered in the same cycle.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Offer bytes with random gaps until max_xfer transfers, loss of busy or
  // the cycle budget. Returns at a negedge with inputs idle.
  task automatic push_bytes(input byte_q_t b, input int max_xfer, input bit rnd_start,
                            output int consumed);
    int budget;
    int cyc;
    bit xf;
    consumed = 0;
    cyc      = 0;
    budget   = 4 * b.size() + 100;
    while (consumed < max_xfer && consumed < b.size() && cyc < budget) begin
      @(negedge clk);
      if (!busy) break;
      in_valid = ($urandom_range(3) != 0);
      in_data  = b[consumed];
      start    = rnd_start && ($urandom_range(15) == 0);
      #1 xf = in_valid && in_ready;
      @(posedge clk);
      if (xf) consumed++;
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input byte_q_t b);
    int c;
    got_q.delete();
    model(b);
    start_pulse();
    push_bytes(b, b.size(), 1'b1, c);
    repeat (2) @(negedge clk);
    check({tag, "_consumed"}, c, exp_consumed);
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    end
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_words"}, words_loaded, exp_words);
  endtask

  initial begin
    int c;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_words", words_loaded, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cpu_hold", cpu_hold, 1);
    check("idle_in_ready", in_ready, 0);
    check("idle_mem_we", mem_we, 0);

    // Two words; check byte 0x42 = XOR of the six preceding bytes.
    fb = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
    send_frame("two_good", fb);
    fb = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00};
    send_frame("two_badchk", fb);
    fb = '{8'h00, 8'h00, 8'h00};
    send_frame("empty", fb);
    // N = 257 exceeds 256 words; trailing bytes must stay unconsumed.
    fb = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame("too_long", fb);
    build_frame(256, 1'b1);
    send_frame("full_cap", fb);

    // Reset after the first word of a three-word frame, then full reload.
    build_frame(3, 1'b1);
    start_pulse();
    push_bytes(fb, 4, 1'b0, c);
    check("mid_consumed", c, 4);
    check("mid_we", mem_we, 1);
    check("mid_addr", mem_addr, 0);
    check("mid_wdata", mem_wdata, {fb[3], fb[2]});
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cpu_hold", cpu_hold, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_words", words_loaded, 0);
    check("mid_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    send_frame("reload", fb);

    for (int k = 0; k < 10; k++) begin
      build_frame($urandom_range(12), $urandom_range(9) < 7);
      send_frame($sformatf("rnd%0d", k), fb);
    end

`ifdef LITE16_LOADER_TIMEOUT_EN
    build_frame(3, 1'b1);
    got_q.delete();
    start_pulse();
    push_bytes(fb, 4, 1'b0, c);
    check("to_consumed", c, 4);
    repeat (15) @(negedge clk);
    check("to_busy_15", busy, 1);
    check("to_error_15", error, 0);
    @(negedge clk);
    check("to_error_16", error, 1);
    check("to_busy_16", busy, 0);
    check("to_cpu_hold", cpu_hold, 1);
    check("to_nwrites", got_q.size(), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
